// File: rtl/rvb_pcpi_arb.sv
// ---------------------------------------------------------------------------
// rvb_pcpi_arb
//
// Purpose:
//   Shares one rvb_pcpi co-processor unit between two PCPI requesters
//   (for example two cores, or a core and a DMA-style helper). A single
//   transaction is in flight at a time. The arbiter latches the winning
//   request into its own operand registers and forwards it to the unit. It
//   then returns the unit's result to the winner as a one-cycle ready pulse.
//
//   Arbitration is either round-robin (RR_EN = 1) or fixed priority with
//   port 0 winning (RR_EN = 0). In both modes the port that was just
//   served is masked for one IDLE cycle. A requester that keeps its valid
//   high back-to-back therefore cannot starve the other port.
//
// Parameters:
//   RR_EN          1 = round-robin between ports, 0 = fixed priority (port 0)
//
// Ports:
//   clk            sole clock, rising edge
//   reset          synchronous, active-high reset
//   rN_pcpi_valid  request from requester N (N = 0,1)
//   rN_pcpi_insn   instruction word of requester N
//   rN_pcpi_rs1/2/3 operands of requester N
//   rN_pcpi_wr     result-valid flag back to requester N (RESP only)
//   rN_pcpi_rd     result back to requester N (RESP only)
//   rN_pcpi_wait   holds off requester N's illegal-instruction trap
//   rN_pcpi_ready  one-cycle completion pulse to requester N
//   u_pcpi_valid   request to the shared unit (BUSY and granted valid)
//   u_pcpi_insn    registered copy of the granted instruction
//   u_pcpi_rs1/2/3 registered copies of the granted operands
//   u_pcpi_wr      result-valid flag from the unit
//   u_pcpi_rd      result from the unit
//   u_pcpi_wait    unit is still working
//   u_pcpi_ready   unit completion pulse
//   grant          one-hot granted port, 2'b00 when idle
// ---------------------------------------------------------------------------
module rvb_pcpi_arb #(
    parameter int RR_EN = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        r0_pcpi_valid,
    input  logic [31:0] r0_pcpi_insn,
    input  logic [31:0] r0_pcpi_rs1,
    input  logic [31:0] r0_pcpi_rs2,
    input  logic [31:0] r0_pcpi_rs3,
    output logic        r0_pcpi_wr,
    output logic [31:0] r0_pcpi_rd,
    output logic        r0_pcpi_wait,
    output logic        r0_pcpi_ready,

    input  logic        r1_pcpi_valid,
    input  logic [31:0] r1_pcpi_insn,
    input  logic [31:0] r1_pcpi_rs1,
    input  logic [31:0] r1_pcpi_rs2,
    input  logic [31:0] r1_pcpi_rs3,
    output logic        r1_pcpi_wr,
    output logic [31:0] r1_pcpi_rd,
    output logic        r1_pcpi_wait,
    output logic        r1_pcpi_ready,

    output logic        u_pcpi_valid,
    output logic [31:0] u_pcpi_insn,
    output logic [31:0] u_pcpi_rs1,
    output logic [31:0] u_pcpi_rs2,
    output logic [31:0] u_pcpi_rs3,
    input  logic        u_pcpi_wr,
    input  logic [31:0] u_pcpi_rd,
    input  logic        u_pcpi_wait,
    input  logic        u_pcpi_ready,

    output logic [1:0]  grant
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    // Round-robin pointer: the port that wins the next tie.
    logic        ptr_q, ptr_d;
    logic [1:0]  mask_q, mask_d;
    logic        wr_q, wr_d;
    logic [31:0] rd_q, rd_d;
    logic [31:0] insn_q, insn_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [31:0] rs3_q, rs3_d;

    logic [1:0]  req_vec;
    logic [1:0]  elig;
    logic [1:0]  sel;
    logic        granted_valid;

    assign req_vec       = {r1_pcpi_valid, r0_pcpi_valid};
    assign elig          = req_vec & ~mask_q;
    assign granted_valid = |(grant_q & req_vec);

    // Winner selection, only meaningful while IDLE. On a tie, round-robin
    // follows the pointer. Fixed priority always takes port 0.
    always_comb begin
        sel = 2'b00;
        if (elig == 2'b11) begin
            if ((RR_EN != 0) && ptr_q) begin
                sel = 2'b10;
            end else begin
                sel = 2'b01;
            end
        end else begin
            sel = elig;
        end
    end

    // Next-state logic for the IDLE -> BUSY -> RESP -> IDLE transaction.
    // The mask holds a value only in the first IDLE cycle after RESP, so it
    // defaults to clear every cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        mask_d  = 2'b00;
        wr_d    = wr_q;
        rd_d    = rd_q;
        insn_d  = insn_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rs3_d   = rs3_q;

        case (state_q)
            S_IDLE: begin
                grant_d = 2'b00;
                if (sel != 2'b00) begin
                    grant_d = sel;
                    state_d = S_BUSY;
                    if (sel[1]) begin
                        insn_d = r1_pcpi_insn;
                        rs1_d  = r1_pcpi_rs1;
                        rs2_d  = r1_pcpi_rs2;
                        rs3_d  = r1_pcpi_rs3;
                    end else begin
                        insn_d = r0_pcpi_insn;
                        rs1_d  = r0_pcpi_rs1;
                        rs2_d  = r0_pcpi_rs2;
                        rs3_d  = r0_pcpi_rs3;
                    end
                end
            end

            S_BUSY: begin
                // A requester that dropped valid has trapped or given up.
                // Abort and ignore any completion from the unit in that
                // same cycle.
                if (!granted_valid) begin
                    state_d = S_IDLE;
                    grant_d = 2'b00;
                end else if (u_pcpi_ready) begin
                    wr_d    = u_pcpi_wr;
                    rd_d    = u_pcpi_rd;
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
                mask_d  = grant_q;
                // Hand the next tie to the port that was not just served.
                ptr_d   = grant_q[0];
            end

            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // State registers. Reset returns to IDLE with the pointer on port 0 and
    // clears every captured value, so all outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            ptr_q   <= 1'b0;
            mask_q  <= 2'b00;
            wr_q    <= 1'b0;
            rd_q    <= 32'd0;
            insn_q  <= 32'd0;
            rs1_q   <= 32'd0;
            rs2_q   <= 32'd0;
            rs3_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            insn_q  <= insn_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rs3_q   <= rs3_d;
        end
    end

    logic busy;
    logic resp;

    assign busy = (state_q == S_BUSY);
    assign resp = (state_q == S_RESP);

    // The unit sees a request only while the granted requester still holds
    // valid. A requester that abandons its request drops u_pcpi_valid in
    // the same cycle.
    assign u_pcpi_valid = busy & granted_valid;
    assign u_pcpi_insn  = insn_q;
    assign u_pcpi_rs1   = rs1_q;
    assign u_pcpi_rs2   = rs2_q;
    assign u_pcpi_rs3   = rs3_q;
    assign grant        = grant_q;

    assign r0_pcpi_ready = resp & grant_q[0];
    assign r1_pcpi_ready = resp & grant_q[1];
    assign r0_pcpi_wr    = r0_pcpi_ready & wr_q;
    assign r1_pcpi_wr    = r1_pcpi_ready & wr_q;
    assign r0_pcpi_rd    = r0_pcpi_ready ? rd_q : 32'd0;
    assign r1_pcpi_rd    = r1_pcpi_ready ? rd_q : 32'd0;

    // The granted port sees the unit's own wait while BUSY. A waiting port
    // that is queued behind another transaction is held off unconditionally.
    assign r0_pcpi_wait = (busy & grant_q[0]) ? u_pcpi_wait
                        : (r0_pcpi_valid & ~grant_q[0] & (state_q != S_IDLE));
    assign r1_pcpi_wait = (busy & grant_q[1]) ? u_pcpi_wait
                        : (r1_pcpi_valid & ~grant_q[1] & (state_q != S_IDLE));

endmodule

// File: tb/tb_rvb_pcpi_arb.sv
// ---------------------------------------------------------------------------
// tb_rvb_pcpi_arb
//
// Directed bench for rvb_pcpi_arb. Two instances share all of the stimulus:
// dut_rr uses round-robin arbitration and dut_fp uses fixed priority. The
// bench plays the shared unit itself and drives its response inputs
// directly. Expected values are written out by hand for each cycle.
// ---------------------------------------------------------------------------
module tb_rvb_pcpi_arb;

    logic        clk;
    logic        reset;

    logic        r0_pcpi_valid, r1_pcpi_valid;
    logic [31:0] r0_pcpi_insn, r0_pcpi_rs1, r0_pcpi_rs2, r0_pcpi_rs3;
    logic [31:0] r1_pcpi_insn, r1_pcpi_rs1, r1_pcpi_rs2, r1_pcpi_rs3;
    logic        u_pcpi_wr, u_pcpi_wait, u_pcpi_ready;
    logic [31:0] u_pcpi_rd;

    logic        r0_pcpi_wr, r0_pcpi_wait, r0_pcpi_ready;
    logic        r1_pcpi_wr, r1_pcpi_wait, r1_pcpi_ready;
    logic [31:0] r0_pcpi_rd, r1_pcpi_rd;
    logic        u_pcpi_valid;
    logic [31:0] u_pcpi_insn, u_pcpi_rs1, u_pcpi_rs2, u_pcpi_rs3;
    logic [1:0]  grant;

    logic        fp_r0_pcpi_wr, fp_r0_pcpi_wait, fp_r0_pcpi_ready;
    logic        fp_r1_pcpi_wr, fp_r1_pcpi_wait, fp_r1_pcpi_ready;
    logic [31:0] fp_r0_pcpi_rd, fp_r1_pcpi_rd;
    logic        fp_u_pcpi_valid;
    logic [31:0] fp_u_pcpi_insn, fp_u_pcpi_rs1, fp_u_pcpi_rs2, fp_u_pcpi_rs3;
    logic [1:0]  fp_grant;

    int checkCount = 0;
    int failCount  = 0;

    rvb_pcpi_arb #(.RR_EN(1)) dut_rr (
        .clk(clk), .reset(reset),
        .r0_pcpi_valid(r0_pcpi_valid), .r0_pcpi_insn(r0_pcpi_insn),
        .r0_pcpi_rs1(r0_pcpi_rs1), .r0_pcpi_rs2(r0_pcpi_rs2), .r0_pcpi_rs3(r0_pcpi_rs3),
        .r0_pcpi_wr(r0_pcpi_wr), .r0_pcpi_rd(r0_pcpi_rd),
        .r0_pcpi_wait(r0_pcpi_wait), .r0_pcpi_ready(r0_pcpi_ready),
        .r1_pcpi_valid(r1_pcpi_valid), .r1_pcpi_insn(r1_pcpi_insn),
        .r1_pcpi_rs1(r1_pcpi_rs1), .r1_pcpi_rs2(r1_pcpi_rs2), .r1_pcpi_rs3(r1_pcpi_rs3),
        .r1_pcpi_wr(r1_pcpi_wr), .r1_pcpi_rd(r1_pcpi_rd),
        .r1_pcpi_wait(r1_pcpi_wait), .r1_pcpi_ready(r1_pcpi_ready),
        .u_pcpi_valid(u_pcpi_valid), .u_pcpi_insn(u_pcpi_insn),
        .u_pcpi_rs1(u_pcpi_rs1), .u_pcpi_rs2(u_pcpi_rs2), .u_pcpi_rs3(u_pcpi_rs3),
        .u_pcpi_wr(u_pcpi_wr), .u_pcpi_rd(u_pcpi_rd),
        .u_pcpi_wait(u_pcpi_wait), .u_pcpi_ready(u_pcpi_ready),
        .grant(grant)
    );

    rvb_pcpi_arb #(.RR_EN(0)) dut_fp (
        .clk(clk), .reset(reset),
        .r0_pcpi_valid(r0_pcpi_valid), .r0_pcpi_insn(r0_pcpi_insn),
        .r0_pcpi_rs1(r0_pcpi_rs1), .r0_pcpi_rs2(r0_pcpi_rs2), .r0_pcpi_rs3(r0_pcpi_rs3),
        .r0_pcpi_wr(fp_r0_pcpi_wr), .r0_pcpi_rd(fp_r0_pcpi_rd),
        .r0_pcpi_wait(fp_r0_pcpi_wait), .r0_pcpi_ready(fp_r0_pcpi_ready),
        .r1_pcpi_valid(r1_pcpi_valid), .r1_pcpi_insn(r1_pcpi_insn),
        .r1_pcpi_rs1(r1_pcpi_rs1), .r1_pcpi_rs2(r1_pcpi_rs2), .r1_pcpi_rs3(r1_pcpi_rs3),
        .r1_pcpi_wr(fp_r1_pcpi_wr), .r1_pcpi_rd(fp_r1_pcpi_rd),
        .r1_pcpi_wait(fp_r1_pcpi_wait), .r1_pcpi_ready(fp_r1_pcpi_ready),
        .u_pcpi_valid(fp_u_pcpi_valid), .u_pcpi_insn(fp_u_pcpi_insn),
        .u_pcpi_rs1(fp_u_pcpi_rs1), .u_pcpi_rs2(fp_u_pcpi_rs2), .u_pcpi_rs3(fp_u_pcpi_rs3),
        .u_pcpi_wr(u_pcpi_wr), .u_pcpi_rd(u_pcpi_rd),
        .u_pcpi_wait(u_pcpi_wait), .u_pcpi_ready(u_pcpi_ready),
        .grant(fp_grant)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when the value differs.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advances one clock edge and leaves time 1 unit past it.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives request valids and the unit response, then lets the
    // combinational outputs settle.
    task automatic applyStimulus(input logic v0, input logic v1, input logic uRdy,
                                 input logic uWr, input logic [31:0] uRd, input logic uWait);
        r0_pcpi_valid = v0;
        r1_pcpi_valid = v1;
        u_pcpi_ready  = uRdy;
        u_pcpi_wr     = uWr;
        u_pcpi_rd     = uRd;
        u_pcpi_wait   = uWait;
        #1;
    endtask

    logic [1:0] expGrant;

    initial begin
        reset = 1'b1;
        r0_pcpi_insn = 32'd0; r0_pcpi_rs1 = 32'd0; r0_pcpi_rs2 = 32'd0; r0_pcpi_rs3 = 32'd0;
        r1_pcpi_insn = 32'd0; r1_pcpi_rs1 = 32'd0; r1_pcpi_rs2 = 32'd0; r1_pcpi_rs3 = 32'd0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        nextCycle();

        // Reset state
        checkOutput("rst_grant", {30'd0, grant}, 32'd0);
        checkOutput("rst_uvalid", {31'd0, u_pcpi_valid}, 32'd0);
        checkOutput("rst_uinsn", u_pcpi_insn, 32'd0);
        checkOutput("rst_r0ready", {31'd0, r0_pcpi_ready}, 32'd0);
        reset = 1'b0;

        // r0 alone, unit ready three cycles after u_pcpi_valid
        r0_pcpi_insn = 32'h6000_1013; r0_pcpi_rs1 = 32'h0000_0004;
        r0_pcpi_rs2 = 32'h0000_0008;  r0_pcpi_rs3 = 32'h0000_000c;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("t1_idle_uvalid", {31'd0, u_pcpi_valid}, 32'd0);
        nextCycle();
        checkOutput("t1_grant", {30'd0, grant}, 32'd1);
        checkOutput("t1_uvalid", {31'd0, u_pcpi_valid}, 32'd1);
        checkOutput("t1_uinsn", u_pcpi_insn, 32'h6000_1013);
        checkOutput("t1_urs1", u_pcpi_rs1, 32'h0000_0004);
        checkOutput("t1_urs3", u_pcpi_rs3, 32'h0000_000c);
        checkOutput("t1_r0wait", {31'd0, r0_pcpi_wait}, 32'd1);
        checkOutput("t1_r1wait", {31'd0, r1_pcpi_wait}, 32'd0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 1'b0);
        checkOutput("t1_early_ready", {31'd0, r0_pcpi_ready}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("t1_r0ready", {31'd0, r0_pcpi_ready}, 32'd1);
        checkOutput("t1_r0wr", {31'd0, r0_pcpi_wr}, 32'd1);
        checkOutput("t1_r0rd", r0_pcpi_rd, 32'h0000_0020);
        checkOutput("t1_r1ready", {31'd0, r1_pcpi_ready}, 32'd0);
        checkOutput("t1_r1rd", r1_pcpi_rd, 32'd0);
        checkOutput("t1_resp_uvalid", {31'd0, u_pcpi_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        checkOutput("t1_after_grant", {30'd0, grant}, 32'd0);
        checkOutput("t1_after_ready", {31'd0, r0_pcpi_ready}, 32'd0);
        checkOutput("t1_hold_uinsn", u_pcpi_insn, 32'h6000_1013);
        nextCycle();

        // Unit declines insn 0x13: ready with wr=0, rd=0
        r0_pcpi_insn = 32'h0000_0013;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        checkOutput("t2_uinsn", u_pcpi_insn, 32'h0000_0013);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        nextCycle();
        checkOutput("t2_r0ready", {31'd0, r0_pcpi_ready}, 32'd1);
        checkOutput("t2_r0wr", {31'd0, r0_pcpi_wr}, 32'd0);
        checkOutput("t2_r0rd", r0_pcpi_rd, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        nextCycle();

        // Round-robin: fresh reset, simultaneous requests
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        r0_pcpi_insn = 32'h0000_0011;
        r1_pcpi_insn = 32'h0000_0022;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        nextCycle();
        checkOutput("t3_grant_a", {30'd0, grant}, 32'd1);
        checkOutput("t3_uinsn_a", u_pcpi_insn, 32'h0000_0011);
        checkOutput("t3_r1wait_a", {31'd0, r1_pcpi_wait}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0111, 1'b1);
        nextCycle();
        checkOutput("t3_r0ready_a", {31'd0, r0_pcpi_ready}, 32'd1);
        checkOutput("t3_r0rd_a", r0_pcpi_rd, 32'h0000_0111);
        checkOutput("t3_r1wait_resp", {31'd0, r1_pcpi_wait}, 32'd1);
        checkOutput("t3_r1ready_a", {31'd0, r1_pcpi_ready}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("t3_r1wait_idle", {31'd0, r1_pcpi_wait}, 32'd1);
        nextCycle();
        checkOutput("t3_idle_r1wait", {31'd0, r1_pcpi_wait}, 32'd0);
        nextCycle();
        checkOutput("t3_grant_b", {30'd0, grant}, 32'd2);
        checkOutput("t3_uinsn_b", u_pcpi_insn, 32'h0000_0022);
        checkOutput("t3_r0wait_b", {31'd0, r0_pcpi_wait}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0222, 1'b1);
        nextCycle();
        checkOutput("t3_r1ready_b", {31'd0, r1_pcpi_ready}, 32'd1);
        checkOutput("t3_r1rd_b", r1_pcpi_rd, 32'h0000_0222);
        checkOutput("t3_r0ready_b", {31'd0, r0_pcpi_ready}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        checkOutput("t3_grant_c", {30'd0, grant}, 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0333, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        nextCycle();
        // Port 0 served last: round-robin now prefers port 1, fixed keeps 0
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        checkOutput("t3_grant_d_rr", {30'd0, grant}, 32'd2);
        checkOutput("t3_grant_d_fp", {30'd0, fp_grant}, 32'd1);
        checkOutput("t3_uinsn_d_fp", fp_u_pcpi_insn, 32'h0000_0011);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0444, 1'b0);
        nextCycle();
        checkOutput("t3_rr_r1ready_d", {31'd0, r1_pcpi_ready}, 32'd1);
        checkOutput("t3_fp_r0ready_d", {31'd0, fp_r0_pcpi_ready}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        nextCycle();

        // Fixed priority with both held: mask alternates the winner
        expGrant = 2'b01;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t4_idle_grant%0d", i), {30'd0, fp_grant}, 32'd0);
            nextCycle();
            checkOutput($sformatf("t4_grant%0d", i), {30'd0, fp_grant}, {30'd0, expGrant});
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h500 + i, 1'b0);
            nextCycle();
            checkOutput($sformatf("t4_ready%0d", i),
                        {30'd0, fp_r1_pcpi_ready, fp_r0_pcpi_ready}, {30'd0, expGrant});
            checkOutput($sformatf("t4_rd%0d", i),
                        expGrant[0] ? fp_r0_pcpi_rd : fp_r1_pcpi_rd, 32'h500 + i);
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
            nextCycle();
            expGrant = ~expGrant;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        nextCycle();

        // r1 abandons after 16 cycles, unit silent
        r1_pcpi_insn = 32'h0000_0077;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        checkOutput("t5_grant", {30'd0, grant}, 32'd2);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("t5_uvalid%0d", i), {31'd0, u_pcpi_valid}, 32'd1);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0bad, 1'b0);
        checkOutput("t5_uvalid_drop", {31'd0, u_pcpi_valid}, 32'd0);
        nextCycle();
        checkOutput("t5_abort_grant", {30'd0, grant}, 32'd0);
        checkOutput("t5_abort_r1ready", {31'd0, r1_pcpi_ready}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        checkOutput("t5_later_r1ready", {31'd0, r1_pcpi_ready}, 32'd0);
        checkOutput("t5_later_r1rd", r1_pcpi_rd, 32'd0);

        // Reset two cycles into BUSY
        r0_pcpi_insn = 32'h0000_0099;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("t6_busy_uvalid", {31'd0, u_pcpi_valid}, 32'd1);
        reset = 1'b1;
        nextCycle();
        checkOutput("t6_grant", {30'd0, grant}, 32'd0);
        checkOutput("t6_uvalid", {31'd0, u_pcpi_valid}, 32'd0);
        checkOutput("t6_uinsn", u_pcpi_insn, 32'd0);
        checkOutput("t6_r0out", {r0_pcpi_ready, r0_pcpi_wr, r0_pcpi_wait, 29'd0}, 32'd0);
        checkOutput("t6_r0rd", r0_pcpi_rd, 32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0abc, 1'b0);
        nextCycle();
        checkOutput("t6_late_r0ready", {31'd0, r0_pcpi_ready}, 32'd0);
        checkOutput("t6_late_r0rd", r0_pcpi_rd, 32'd0);
        checkOutput("t6_late_grant", {30'd0, grant}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        nextCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
